noise_load_ctrl: RTL and testbench
==================================

NOISE_LOAD_CTRL -- requirements
Module: noise_load_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with ports clk and rst.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 start  input  1  single-cycle request to load the table and run; honoured only in IDLE.
REQ-005 stop  input  1  abort or finish request; honoured in any non-IDLE state.
REQ-006 num_words  input  8  number of 64-bit table words to load (1..255); sampled on an accepted start.
REQ-007 run_len  input  16  samples to run before finishing (0 = run until stop); sampled on an accepted start.
REQ-008 src_data  input  64  table word from the source stream.
REQ-009 src_valid  input  1  src_data valid.
REQ-010 src_ready  output  1  controller accepts src_data this cycle.
REQ-011 mem_data  output  64  table word to the noise generator.
REQ-012 location  output  8  table index of mem_data.
REQ-013 load_mem  output  1  one-cycle table write strobe to the noise generator.
REQ-014 done_wait  input  1  noise generator ready (warm-up complete).
REQ-015 sample_valid  input  1  noise generator produced a sample this cycle.
REQ-016 noise_en  output  1  enable to the noise generator.
REQ-017 busy  output  1  state is not IDLE.
REQ-018 run_done  output  1  one-cycle pulse on entering DONE.
REQ-019 error  output  1  sticky warm-up timeout flag.
REQ-020 sample_cnt  output  16  samples counted in the current or last run.

Function
REQ-021 The FSM SHALL have states IDLE, LOAD, WAIT_GEN, RUN and DONE.
REQ-022 In IDLE, start=1 with num_words!=0 and stop=0 SHALL latch num_words and run_len, clear sample_cnt, word_cnt and error, and go to LOAD; any other start SHALL be ignored.
REQ-023 src_ready SHALL be combinational, equal to (state==LOAD) && !stop.
REQ-024 On each src_valid && src_ready handshake, mem_data<=src_data, location<=word_cnt and load_mem<=1 SHALL all be registered; load_mem SHALL be 0 in every cycle without a handshake in the previous cycle.
REQ-025 word_cnt SHALL increment on each handshake; the handshake with word_cnt==num_words-1 SHALL move the FSM to WAIT_GEN.
REQ-026 noise_en SHALL be registered and equal to 1 exactly while in WAIT_GEN or RUN.
REQ-027 In WAIT_GEN, a 16-bit timeout counter SHALL increment each cycle; done_wait=1 SHALL go to RUN; reaching 16'hFFFF without done_wait SHALL set error and return to IDLE with no run_done pulse.
REQ-028 In RUN, each sample_valid SHALL increment sample_cnt, saturating at 16'hFFFF.
REQ-029 In RUN with run_len!=0, the sample_valid that makes sample_cnt equal run_len SHALL move the FSM to DONE.
REQ-030 stop=1 in LOAD, WAIT_GEN or RUN SHALL move the FSM to DONE next cycle; a handshake in that cycle SHALL be impossible, because src_ready is 0.
REQ-031 stop and run-length completion in the same cycle SHALL give a single DONE entry; a sample_valid in that cycle SHALL still be counted.
REQ-032 DONE SHALL assert run_done for exactly one cycle and return to IDLE; sample_cnt SHALL hold until the next accepted start.
REQ-033 stop in IDLE SHALL have no effect; start in any non-IDLE state SHALL be ignored.

Reset
REQ-034 rst SHALL force IDLE and zero src_ready, mem_data, location, load_mem, noise_en, busy, run_done, error, sample_cnt, word_cnt and the timeout counter, at any point in a sequence.

Structure
REQ-035 A shared package noise_ctrl_pkg SHALL hold the state enum, the TIMEOUT_MAX constant (16'hFFFF) and the width constants (data 64, location 8, count 16).
REQ-036 The block SHALL be a single module with no sub-modules; the noise generator instance is outside this block.

Verification
REQ-037 start, num_words=4, src_valid held 1 -> four load_mem pulses at location 0,1,2,3 with matching mem_data, then noise_en=1.
REQ-038 done_wait rises 10 cycles after WAIT_GEN with run_len=5 and continuous sample_valid -> sample_cnt=5, one run_done pulse, noise_en=0, IDLE.
REQ-039 src_valid toggling 1/0 with num_words=3 -> exactly 3 load_mem pulses and no index skipped.
REQ-040 done_wait held 0 -> error=1 after 65535 WAIT_GEN cycles, IDLE, no run_done.
REQ-041 run_len=0 with stop after 20 samples -> sample_cnt=20, run_done pulse; stop during LOAD -> src_ready=0 that cycle, DONE next.
REQ-042 rst asserted mid-RUN -> all outputs 0 immediately; a following start restarts from location 0.

Source files
------------

// File: rtl/noise_ctrl_pkg.sv
// Shared types and constants for the noise generator table-load controller.
// The state enum and the width constants live here so that other blocks use the same values.
package noise_ctrl_pkg;

   localparam int DATA_W = 64;
   localparam int LOC_W  = 8;
   localparam int CNT_W  = 16;

   localparam logic [CNT_W-1:0] TIMEOUT_MAX = 16'hFFFF;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WAIT_GEN,
      RUN,
      DONE
   } state_t;

endpackage

// File: rtl/noise_load_ctrl.sv
// Loads a table of 64-bit words into the noise generator, waits for its warm-up to finish,
// and then counts samples until the programmed run length is reached or a stop request arrives.
module noise_load_ctrl
   import noise_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic [LOC_W-1:0]  num_words,
   input  logic [CNT_W-1:0]  run_len,
   input  logic [DATA_W-1:0] src_data,
   input  logic              src_valid,
   output logic              src_ready,
   output logic [DATA_W-1:0] mem_data,
   output logic [LOC_W-1:0]  location,
   output logic              load_mem,
   input  logic              done_wait,
   input  logic              sample_valid,
   output logic              noise_en,
   output logic              busy,
   output logic              run_done,
   output logic              error,
   output logic [CNT_W-1:0]  sample_cnt
);

   state_t           state, next_state;
   logic [LOC_W-1:0] num_words_q, word_cnt;
   logic [CNT_W-1:0] run_len_q, timeout_cnt;
   logic             handshake, accept, last_word, run_complete, timeout_hit;

   // A stop request closes the input the same cycle, so the aborted load can take no partial word.
   assign src_ready    = (state == LOAD) && !stop;
   assign busy         = (state != IDLE);
   assign handshake    = src_valid && src_ready;
   assign accept       = (state == IDLE) && start && !stop && (num_words != '0);
   assign last_word    = (word_cnt == num_words_q - LOC_W'(1));
   assign run_complete = (run_len_q != '0) && sample_valid
                         && (sample_cnt + CNT_W'(1) == run_len_q);
   assign timeout_hit  = (state == WAIT_GEN) && !stop && !done_wait
                         && (timeout_cnt == TIMEOUT_MAX - CNT_W'(1));

   always_comb begin
      // NOTE: next_state gets a default before the case, so no path leaves it unassigned and no latch is inferred.
      next_state = state;
      case (state)
         IDLE:     if (accept) next_state = LOAD;
         LOAD: begin
            if (stop)                         next_state = DONE;
            else if (handshake && last_word)  next_state = WAIT_GEN;
         end
         WAIT_GEN: begin
            if (stop)             next_state = DONE;
            else if (done_wait)   next_state = RUN;
            else if (timeout_hit) next_state = IDLE;
         end
         RUN:      if (stop || run_complete) next_state = DONE;
         DONE:     next_state = IDLE;
         default:  next_state = IDLE;
      endcase
   end

   // NOTE: every register below uses non-blocking assignments, so all of them update from the same pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         mem_data    <= '0;
         location    <= '0;
         load_mem    <= 1'b0;
         noise_en    <= 1'b0;
         run_done    <= 1'b0;
         error       <= 1'b0;
         sample_cnt  <= '0;
         word_cnt    <= '0;
         timeout_cnt <= '0;
         num_words_q <= '0;
         run_len_q   <= '0;
      end else begin
         state       <= next_state;
         load_mem    <= handshake;
         noise_en    <= (next_state == WAIT_GEN) || (next_state == RUN);
         run_done    <= (next_state == DONE);
         timeout_cnt <= (state == WAIT_GEN) ? timeout_cnt + CNT_W'(1) : '0;

         if (accept) begin
            num_words_q <= num_words;
            run_len_q   <= run_len;
            sample_cnt  <= '0;
            word_cnt    <= '0;
            error       <= 1'b0;
         end

         if (handshake) begin
            mem_data <= src_data;
            location <= word_cnt;
            word_cnt <= word_cnt + LOC_W'(1);
         end

         if (timeout_hit) error <= 1'b1;

         if ((state == RUN) && sample_valid && (sample_cnt != TIMEOUT_MAX))
            sample_cnt <= sample_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_noise_load_ctrl.sv
// Directed bench for noise_load_ctrl: one cycle-by-cycle vector table followed by
// hand-written sequences for the multi-cycle cases (toggled valid, warm-up timeout, stop, reset).
module tb_noise_load_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, stop;
   logic [7:0]  num_words;
   logic [15:0] run_len;
   logic [63:0] src_data;
   logic        src_valid;
   logic        src_ready;
   logic [63:0] mem_data;
   logic [7:0]  location;
   logic        load_mem;
   logic        done_wait, sample_valid;
   logic        noise_en, busy, run_done, error;
   logic [15:0] sample_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   noise_load_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .stop         (stop),
      .num_words    (num_words),
      .run_len      (run_len),
      .src_data     (src_data),
      .src_valid    (src_valid),
      .src_ready    (src_ready),
      .mem_data     (mem_data),
      .location     (location),
      .load_mem     (load_mem),
      .done_wait    (done_wait),
      .sample_valid (sample_valid),
      .noise_en     (noise_en),
      .busy         (busy),
      .run_done     (run_done),
      .error        (error),
      .sample_cnt   (sample_cnt)
   );

   typedef struct {
      logic        start, stop;
      logic [7:0]  nw;
      logic [15:0] rl;
      logic [63:0] data;
      logic        sv, dw, smp;
      logic        e_rdy, e_load;
      logic [7:0]  e_loc;
      logic [63:0] e_mem;
      logic        e_en, e_busy, e_done;
      logic [15:0] e_cnt;
      logic        e_err;
   } vec_t;

   vec_t vecs[18];

   function automatic vec_t mk(logic st, logic sp, logic [7:0] nw, logic [15:0] rl,
                               logic [63:0] d, logic sv, logic dw, logic smp,
                               logic rdy, logic ld, logic [7:0] loc, logic [63:0] mem,
                               logic en, logic bsy, logic dn, logic [15:0] cnt, logic err);
      vec_t v;
      v.start = st;  v.stop = sp;  v.nw = nw;  v.rl = rl;  v.data = d;
      v.sv = sv;  v.dw = dw;  v.smp = smp;
      v.e_rdy = rdy;  v.e_load = ld;  v.e_loc = loc;  v.e_mem = mem;
      v.e_en = en;  v.e_busy = bsy;  v.e_done = dn;  v.e_cnt = cnt;  v.e_err = err;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic clear_inputs();
      start = 0; stop = 0; num_words = 0; run_len = 0; src_data = 0;
      src_valid = 0; done_wait = 0; sample_valid = 0;
   endtask

   // Returns just after the negedge of the first LOAD cycle.
   task automatic start_run(input logic [7:0] nw, input logic [15:0] rl);
      @(negedge clk);
      start = 1; num_words = nw; run_len = rl;
      @(negedge clk);
      start = 0; num_words = 0; run_len = 0;
   endtask

   initial begin
      logic [63:0] exp_data[$];
      int pulses, idx, en_cycles, done_cnt;
      bit seen;

      clear_inputs();
      rst = 1;
      @(negedge clk); @(negedge clk);
      #1;
      check("reset_busy", busy, 0);
      check("reset_noise_en", noise_en, 0);
      rst = 0;

      // Table: full flow with num_words=4, run_len=3, then ignored start/stop cases.
      //           st sp nw rl data      sv dw smp  rdy ld loc mem      en bsy dn cnt err
      vecs[0]  = mk(0, 0, 0, 0, 64'h0,    0, 0, 0,   0, 0, 0, 64'h0,   0, 0, 0, 0, 0);
      vecs[1]  = mk(1, 0, 4, 3, 64'h0,    0, 0, 0,   0, 0, 0, 64'h0,   0, 0, 0, 0, 0);
      vecs[2]  = mk(0, 0, 0, 0, 64'h11,   1, 0, 0,   1, 0, 0, 64'h0,   0, 1, 0, 0, 0);
      vecs[3]  = mk(0, 0, 0, 0, 64'h22,   1, 0, 0,   1, 1, 0, 64'h11,  0, 1, 0, 0, 0);
      vecs[4]  = mk(0, 0, 0, 0, 64'h33,   1, 0, 0,   1, 1, 1, 64'h22,  0, 1, 0, 0, 0);
      vecs[5]  = mk(0, 0, 0, 0, 64'h44,   1, 0, 0,   1, 1, 2, 64'h33,  0, 1, 0, 0, 0);
      vecs[6]  = mk(0, 0, 0, 0, 64'h55,   1, 0, 0,   0, 1, 3, 64'h44,  1, 1, 0, 0, 0);
      vecs[7]  = mk(0, 0, 0, 0, 64'h0,    0, 0, 0,   0, 0, 3, 64'h44,  1, 1, 0, 0, 0);
      vecs[8]  = mk(0, 0, 0, 0, 64'h0,    0, 1, 0,   0, 0, 3, 64'h44,  1, 1, 0, 0, 0);
      vecs[9]  = mk(0, 0, 0, 0, 64'h0,    0, 0, 1,   0, 0, 3, 64'h44,  1, 1, 0, 0, 0);
      vecs[10] = mk(0, 0, 0, 0, 64'h0,    0, 0, 0,   0, 0, 3, 64'h44,  1, 1, 0, 1, 0);
      vecs[11] = mk(0, 0, 0, 0, 64'h0,    0, 0, 1,   0, 0, 3, 64'h44,  1, 1, 0, 1, 0);
      vecs[12] = mk(1, 0, 0, 0, 64'h0,    0, 0, 1,   0, 0, 3, 64'h44,  1, 1, 0, 2, 0);
      vecs[13] = mk(0, 0, 0, 0, 64'h0,    0, 0, 0,   0, 0, 3, 64'h44,  0, 1, 1, 3, 0);
      vecs[14] = mk(0, 1, 0, 0, 64'h0,    0, 0, 0,   0, 0, 3, 64'h44,  0, 0, 0, 3, 0);
      vecs[15] = mk(0, 1, 0, 0, 64'h0,    0, 0, 0,   0, 0, 3, 64'h44,  0, 0, 0, 3, 0);
      vecs[16] = mk(1, 0, 0, 0, 64'h0,    0, 0, 0,   0, 0, 3, 64'h44,  0, 0, 0, 3, 0);
      vecs[17] = mk(0, 0, 0, 0, 64'h0,    0, 0, 0,   0, 0, 3, 64'h44,  0, 0, 0, 3, 0);

      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         start = vecs[i].start;  stop = vecs[i].stop;  num_words = vecs[i].nw;
         run_len = vecs[i].rl;   src_data = vecs[i].data;  src_valid = vecs[i].sv;
         done_wait = vecs[i].dw; sample_valid = vecs[i].smp;
         #1;
         check($sformatf("v%0d_src_ready", i),  src_ready,  vecs[i].e_rdy);
         check($sformatf("v%0d_load_mem", i),   load_mem,   vecs[i].e_load);
         check($sformatf("v%0d_location", i),   location,   vecs[i].e_loc);
         check($sformatf("v%0d_mem_data", i),   mem_data,   vecs[i].e_mem);
         check($sformatf("v%0d_noise_en", i),   noise_en,   vecs[i].e_en);
         check($sformatf("v%0d_busy", i),       busy,       vecs[i].e_busy);
         check($sformatf("v%0d_run_done", i),   run_done,   vecs[i].e_done);
         check($sformatf("v%0d_sample_cnt", i), sample_cnt, vecs[i].e_cnt);
         check($sformatf("v%0d_error", i),      error,      vecs[i].e_err);
      end
      clear_inputs();

      // src_valid toggling with num_words=3: three pulses, consecutive locations.
      start_run(3, 0);
      pulses = 0;
      for (int c = 0; c < 12; c++) begin
         src_valid = (c % 2 == 0);
         src_data  = 64'hC0DE_0000_0000_0000 + 64'(c);
         if (src_valid && exp_data.size() < 3) exp_data.push_back(src_data);
         #1;
         if (load_mem) begin
            idx = pulses;
            check("toggle_location", location, 64'(idx));
            check("toggle_mem_data", mem_data, (idx < exp_data.size()) ? exp_data[idx] : 64'hx);
            pulses++;
         end
         @(negedge clk);
      end
      src_valid = 0;
      #1;
      check("toggle_pulses", pulses, 3);
      check("toggle_noise_en", noise_en, 1);
      stop = 1;
      @(negedge clk);
      stop = 0;
      #1;
      check("toggle_stop_run_done", run_done, 1);
      @(negedge clk);
      #1;
      check("toggle_idle_busy", busy, 0);

      // done_wait 10 cycles into WAIT_GEN, run_len=5, continuous samples.
      start_run(1, 5);
      src_valid = 1; src_data = 64'hBEEF; sample_valid = 1;
      @(negedge clk);
      src_valid = 0;
      #1;
      check("wait_noise_en", noise_en, 1);
      repeat (10) @(negedge clk);
      done_wait = 1;
      done_cnt = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         done_wait = 0;
         #1;
         if (run_done) done_cnt++;
      end
      sample_valid = 0;
      check("run5_sample_cnt", sample_cnt, 5);
      check("run5_done_pulses", done_cnt, 1);
      check("run5_noise_en", noise_en, 0);
      check("run5_busy", busy, 0);

      // Warm-up timeout: noise_en must stay high for exactly 65535 cycles.
      start_run(1, 0);
      src_valid = 1; src_data = 64'h7777;
      @(negedge clk);
      src_valid = 0;
      en_cycles = 0; done_cnt = 0; seen = 0;
      for (int c = 0; c < 70000; c++) begin
         #1;
         if (noise_en) begin
            en_cycles++;
            seen = 1;
         end
         if (run_done) done_cnt++;
         if (seen && !noise_en) break;
         @(negedge clk);
      end
      check("timeout_cycles", en_cycles, 65535);
      check("timeout_error", error, 1);
      check("timeout_busy", busy, 0);
      check("timeout_no_run_done", done_cnt, 0);
      start_run(2, 0);
      #1;
      check("start_clears_error", error, 0);
      stop = 1;
      #1;
      check("stop_in_load_src_ready", src_ready, 0);
      src_valid = 1; src_data = 64'hDEAD;
      @(negedge clk);
      stop = 0; src_valid = 0;
      #1;
      check("stop_in_load_run_done", run_done, 1);
      check("stop_in_load_no_write", load_mem, 0);
      @(negedge clk);

      // run_len=0, stop after 20 samples.
      start_run(1, 0);
      src_valid = 1; src_data = 64'h1234;
      @(negedge clk);
      src_valid = 0; done_wait = 1;
      @(negedge clk);
      done_wait = 0; sample_valid = 1;
      repeat (19) @(negedge clk);
      @(negedge clk);
      sample_valid = 0; stop = 1;
      @(negedge clk);
      stop = 0;
      #1;
      check("runlen0_run_done", run_done, 1);
      check("runlen0_sample_cnt", sample_cnt, 20);
      @(negedge clk);

      // stop and run-length completion in the same cycle: one DONE, sample still counted.
      start_run(1, 2);
      src_valid = 1; src_data = 64'h2222;
      @(negedge clk);
      src_valid = 0; done_wait = 1;
      @(negedge clk);
      done_wait = 0; sample_valid = 1;
      @(negedge clk);
      stop = 1;
      done_cnt = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         stop = 0; sample_valid = 0;
         #1;
         if (run_done) done_cnt++;
      end
      check("stop_and_len_pulses", done_cnt, 1);
      check("stop_and_len_cnt", sample_cnt, 2);

      // Asynchronous reset in the middle of RUN, then a clean restart.
      start_run(2, 0);
      src_valid = 1; src_data = 64'hAAAA;
      @(negedge clk);
      src_data = 64'hBBBB;
      @(negedge clk);
      src_valid = 0; done_wait = 1;
      @(negedge clk);
      done_wait = 0; sample_valid = 1;
      @(negedge clk);
      @(negedge clk);
      #2;
      rst = 1;
      #1;
      check("rst_busy", busy, 0);
      check("rst_noise_en", noise_en, 0);
      check("rst_sample_cnt", sample_cnt, 0);
      check("rst_mem_data", mem_data, 0);
      check("rst_location", location, 0);
      check("rst_load_mem", load_mem, 0);
      check("rst_run_done", run_done, 0);
      check("rst_error", error, 0);
      check("rst_src_ready", src_ready, 0);
      sample_valid = 0;
      @(negedge clk);
      rst = 0;
      start_run(2, 0);
      src_valid = 1; src_data = 64'hCCCC;
      @(negedge clk);
      src_data = 64'hDDDD;
      #1;
      check("restart_loc0", location, 0);
      check("restart_mem0", mem_data, 64'hCCCC);
      check("restart_load0", load_mem, 1);
      @(negedge clk);
      src_valid = 0;
      #1;
      check("restart_loc1", location, 1);
      check("restart_mem1", mem_data, 64'hDDDD);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
